// File: rtl/ser_frame_tx_if.sv
// Parallel-word / serial-frame bundle for ser_frame_tx.
// slave modport is the framer; master modport is the word source.
// Optional err_inj_i exists only when SER_FRAME_TX_ERR_INJ_EN is defined.
interface ser_frame_tx_if;
  logic [9:0] prl_data_i;
  logic [3:0] prl_len_i;
  logic       prl_valid_i;
  logic       prl_ready_o;
  logic       ser_data_o;
  logic       ser_data_en_o;
  logic       busy_o;
  logic       drop_o;
`ifdef SER_FRAME_TX_ERR_INJ_EN
  logic       err_inj_i;
`endif

  modport slave (
`ifdef SER_FRAME_TX_ERR_INJ_EN
    input  err_inj_i,
`endif
    input  prl_data_i,
    input  prl_len_i,
    input  prl_valid_i,
    output prl_ready_o,
    output ser_data_o,
    output ser_data_en_o,
    output busy_o,
    output drop_o
  );

  modport master (
`ifdef SER_FRAME_TX_ERR_INJ_EN
    output err_inj_i,
`endif
    output prl_data_i,
    output prl_len_i,
    output prl_valid_i,
    input  prl_ready_o,
    input  ser_data_o,
    input  ser_data_en_o,
    input  busy_o,
    input  drop_o
  );
endinterface

// File: rtl/ser_frame_tx.sv
// Serial framer: preamble, 2..10 data bits MSB first, even parity, then an idle gap.
// Latency: first preamble bit on ser_data_o the cycle after accept; serial outputs registered.
// Backpressure: prl_ready_o high only in IDLE; SER_FRAME_TX_ERR_INJ_EN adds err_inj_i (inverts parity).
module ser_frame_tx #(
  parameter logic [3:0] PREAMB = 4'b1010,
  parameter int         GAP    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ser_frame_tx_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] data_q, data_d;
  logic [3:0] len_q, len_d;
  logic       par_q, par_d;
  logic       drop_q, drop_d;
  logic       ser_data_q, ser_data_d;
  logic       ser_en_q, ser_en_d;

  logic        inj;
  logic [15:0] mask_full;
  logic [9:0]  mask;
  logic        len_legal;
  logic [3:0]  bit_idx;

`ifdef SER_FRAME_TX_ERR_INJ_EN
  assign inj = bus.err_inj_i;
`else
  assign inj = 1'b0;
`endif

  // Payload mask and legality for the word currently offered.
  always_comb begin
    mask_full = (16'd1 << bus.prl_len_i) - 16'd1;
    mask      = mask_full[9:0];
    len_legal = (bus.prl_len_i >= 4'd2) && (bus.prl_len_i <= 4'd10);
  end

  // Frame sequencing: accept/latch in IDLE, walk PRE -> DATA -> PAR -> GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    par_d   = par_q;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.prl_valid_i) begin
          data_d = bus.prl_data_i & mask;
          len_d  = bus.prl_len_i;
          par_d  = (^(bus.prl_data_i & mask)) ^ inj;
          if (len_legal) begin
            state_d = S_PRE;
            cnt_d   = 4'd0;
          end else begin
            // Illegal length: word is consumed but nothing is emitted.
            drop_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd3) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == len_q - 4'd1) begin
          state_d = S_PAR;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_PAR: begin
        state_d = S_GAP;
        cnt_d   = 4'd0;
      end
      S_GAP: begin
        if (cnt_q == GAP_M1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Serial outputs are decoded from the next state so the registered bit lines up with state_q.
  always_comb begin
    ser_en_d   = 1'b0;
    ser_data_d = 1'b0;
    bit_idx    = len_d - 4'd1 - cnt_d;
    case (state_d)
      S_PRE: begin
        ser_en_d   = 1'b1;
        ser_data_d = PREAMB[2'd3 - cnt_d[1:0]];
      end
      S_DATA: begin
        ser_en_d   = 1'b1;
        ser_data_d = data_d[bit_idx];
      end
      S_PAR: begin
        ser_en_d   = 1'b1;
        ser_data_d = par_d;
      end
      default: begin
        ser_en_d   = 1'b0;
        ser_data_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills an in-flight frame immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      data_q     <= 10'd0;
      len_q      <= 4'd0;
      par_q      <= 1'b0;
      drop_q     <= 1'b0;
      ser_data_q <= 1'b0;
      ser_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      len_q      <= len_d;
      par_q      <= par_d;
      drop_q     <= drop_d;
      ser_data_q <= ser_data_d;
      ser_en_q   <= ser_en_d;
    end
  end

  assign bus.prl_ready_o   = (state_q == S_IDLE);
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.ser_data_o    = ser_data_q;
  assign bus.ser_data_en_o = ser_en_q;
  assign bus.drop_o        = drop_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed bench for ser_frame_tx: captures each enable burst as a frame and
// compares it, the idle runs between frames and the handshake flags to
// hand-computed values.
module tb_ser_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ser_frame_tx_if ifc ();

  ser_frame_tx #(.PREAMB(4'b1010), .GAP(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Serial capture: one entry per enable burst, plus the low-run before each burst.
  logic [15:0] shreg = 16'd0;
  int          nbits = 0;
  int          low_run = 0;
  bit          seen = 1'b0;
  int          en_cycles = 0;
  int          drop_cnt = 0;
  int          low_viol = 0;
  logic [15:0] fr_bits[$];
  int          fr_len[$];
  int          gaps[$];

  always @(negedge clk) begin
    if (ifc.ser_data_en_o === 1'b1) begin
      if (nbits == 0 && seen) gaps.push_back(low_run);
      low_run = 0;
      shreg = {shreg[14:0], ifc.ser_data_o};
      nbits++;
      en_cycles++;
    end else begin
      if (nbits > 0) begin
        fr_bits.push_back(shreg);
        fr_len.push_back(nbits);
        shreg = 16'd0;
        nbits = 0;
        seen = 1'b1;
      end
      low_run++;
      if (ifc.ser_data_o !== 1'b0) low_viol++;
    end
    if (ifc.drop_o === 1'b1) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge once prl_ready_o is high.
  task automatic wait_ready();
    int n = 0;
    while (ifc.prl_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Offers one word for exactly one edge, then scrambles the inputs to show they are ignored.
  // Returns at the negedge just after the accepting edge.
  task automatic do_accept(input logic [9:0] d, input logic [3:0] l);
    wait_ready();
    ifc.prl_data_i  = d;
    ifc.prl_len_i   = l;
    ifc.prl_valid_i = 1'b1;
    @(negedge clk);
    ifc.prl_valid_i = 1'b0;
    ifc.prl_data_i  = d ^ 10'h3FF;
    ifc.prl_len_i   = 4'd7;
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (fr_len.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("frame_count", 32'(fr_len.size()), 32'(n));
  endtask

  initial begin
    int fb;
    int gb;
    int en_before;
    int drop_before;

    ifc.prl_data_i  = 10'd0;
    ifc.prl_len_i   = 4'd0;
    ifc.prl_valid_i = 1'b0;
`ifdef SER_FRAME_TX_ERR_INJ_EN
    ifc.err_inj_i   = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_en",    32'(ifc.ser_data_en_o), 32'd0);
    check("rst_data",  32'(ifc.ser_data_o),    32'd0);
    check("rst_drop",  32'(ifc.drop_o),        32'd0);
    check("rst_busy",  32'(ifc.busy_o),        32'd0);
    check("rst_ready", 32'(ifc.prl_ready_o),   32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Full-length word 0x2B5: 1010_1010110101_0
    do_accept(10'h2B5, 4'd10);
    check("lat1_en",    32'(ifc.ser_data_en_o), 32'd1);
    check("lat1_bit",   32'(ifc.ser_data_o),    32'd1);
    check("lat1_busy",  32'(ifc.busy_o),        32'd1);
    check("lat1_ready", 32'(ifc.prl_ready_o),   32'd0);
    @(negedge clk);
    check("pre_bit2",   32'(ifc.ser_data_o),    32'd0);
    wait_frames(1);
    check("f0_len",  32'(fr_len[0]),  32'd15);
    check("f0_bits", 32'(fr_bits[0]), 32'(15'b1010_1010110101_0));

    // Upper bits ignored: 0x3F5 len 3 -> 1010_101_0
    do_accept(10'h3F5, 4'd3);
    wait_frames(2);
    check("f1_len",  32'(fr_len[1]),  32'd8);
    check("f1_bits", 32'(fr_bits[1]), 32'(8'b1010_101_0));

    // Illegal lengths 1 then 12 with valid held
    wait_ready();
    en_before   = en_cycles;
    drop_before = drop_cnt;
    ifc.prl_data_i  = 10'h155;
    ifc.prl_len_i   = 4'd1;
    ifc.prl_valid_i = 1'b1;
    @(negedge clk);
    check("drop_len1",   32'(ifc.drop_o),      32'd1);
    check("drop_ready1", 32'(ifc.prl_ready_o), 32'd1);
    ifc.prl_len_i = 4'd12;
    @(negedge clk);
    check("drop_len12",  32'(ifc.drop_o),      32'd1);
    check("drop_ready2", 32'(ifc.prl_ready_o), 32'd1);
    ifc.prl_valid_i = 1'b0;
    @(negedge clk);
    check("drop_clear",  32'(ifc.drop_o),      32'd0);
    repeat (3) @(negedge clk);
    check("drop_no_en",  32'(en_cycles),            32'(en_before));
    check("drop_pulses", 32'(drop_cnt - drop_before), 32'd2);

    // Three words with valid held high: len 2 (0x003), 10 (0x155), 5 (0x013)
    fb = fr_len.size();
    gb = gaps.size();
    wait_ready();
    ifc.prl_data_i  = 10'h003;
    ifc.prl_len_i   = 4'd2;
    ifc.prl_valid_i = 1'b1;
    @(negedge clk);
    ifc.prl_data_i  = 10'h155;
    ifc.prl_len_i   = 4'd10;
    wait_ready();
    @(negedge clk);
    ifc.prl_data_i  = 10'h013;
    ifc.prl_len_i   = 4'd5;
    wait_ready();
    @(negedge clk);
    ifc.prl_valid_i = 1'b0;
    wait_frames(fb + 3);
    check("b2b0_len",  32'(fr_len[fb]),     32'd7);
    check("b2b0_bits", 32'(fr_bits[fb]),    32'(7'b1010_11_0));
    check("b2b1_len",  32'(fr_len[fb+1]),   32'd15);
    check("b2b1_bits", 32'(fr_bits[fb+1]),  32'(15'b1010_0101010101_1));
    check("b2b2_len",  32'(fr_len[fb+2]),   32'd10);
    check("b2b2_bits", 32'(fr_bits[fb+2]),  32'(10'b1010_10011_1));
    check("gap_count", 32'(gaps.size() - gb), 32'd3);
    check("gap_1",     32'(gaps[gb+1]),     32'd3);
    check("gap_2",     32'(gaps[gb+2]),     32'd3);

    // Reset in the middle of the data phase
    do_accept(10'h3FF, 4'd10);
    repeat (6) @(negedge clk);
    check("mid_en_before", 32'(ifc.ser_data_en_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_en_async",  32'(ifc.ser_data_en_o), 32'd0);
    check("mid_busy",      32'(ifc.busy_o),        32'd0);
    check("mid_ready",     32'(ifc.prl_ready_o),   32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_no_resume", 32'(ifc.ser_data_en_o), 32'd0);
    fb = fr_len.size();
    do_accept(10'h0A3, 4'd8);
    wait_frames(fb + 1);
    check("post_rst_len",  32'(fr_len[fb]),  32'd13);
    check("post_rst_bits", 32'(fr_bits[fb]), 32'(13'b1010_10100011_0));

`ifdef SER_FRAME_TX_ERR_INJ_EN
    // Inverted parity: 0x00F len 4 -> 1010_1111_1
    fb = fr_len.size();
    wait_ready();
    ifc.err_inj_i = 1'b1;
    do_accept(10'h00F, 4'd4);
    ifc.err_inj_i = 1'b0;
    wait_frames(fb + 1);
    check("inj_len",  32'(fr_len[fb]),  32'd9);
    check("inj_bits", 32'(fr_bits[fb]), 32'(9'b1010_1111_1));
`endif

    repeat (4) @(negedge clk);
    check("data_low_when_idle", 32'(low_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
